// File: rtl/dsm_pkg.sv
// dsm_pkg: shared types, constants and helper functions for the CIFB
// delta-sigma modulator (dsm_cifb) and its integrator stages.
//   wide_t      - full-precision signed working type for stage arithmetic
//   fs_of()     - full-scale value for a given input width
//   sat()       - clip a wide value to a signed w-bit range
//   lfsr_next() - one step of the x^16+x^14+x^13+x^11+1 Fibonacci LFSR
package dsm_pkg;

  localparam int MAX_ORDER = 4;
  localparam int WIDE_W    = 64;

  typedef logic signed [WIDE_W-1:0] wide_t;

  // Seed and tap mask (bits 15,13,12,10) of the dither LFSR.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {
    COEF_FB   = 1'b0,
    COEF_GAIN = 1'b1
  } coef_sel_e;

  typedef enum logic {
    OVL_IDLE  = 1'b0,
    OVL_COUNT = 1'b1
  } ovl_state_e;

  // Full scale is a quarter of the input range, leaving 2 bits of headroom.
  function automatic wide_t fs_of(input int data_w);
    return wide_t'(1) <<< (data_w - 2);
  endfunction

  function automatic wide_t sat(input wide_t x, input int w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {x[14:0], ^(x & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/dsm_cifb_if.sv
// dsm_cifb_if: sample/control bus of the CIFB modulator.
//   master (source/controller side): drives ce, vin, coefficient port,
//     dith_en, ovl_clr; observes pwm, ovl_event, ovl_sticky, sat_flag.
//   slave (modulator side): the mirror image.
interface dsm_cifb_if #(
  parameter int DATA_W = 20,
  parameter int ACC_W  = 24
);
  import dsm_pkg::*;

  logic                     ce;
  logic signed [DATA_W-1:0] vin;
  logic                     pwm;
  logic                     coef_we;
  coef_sel_e                coef_sel;
  logic [1:0]               coef_idx;
  logic [ACC_W-1:0]         coef_wdata;
  logic                     coef_commit;
  logic                     dith_en;
  logic                     ovl_clr;
  logic                     ovl_event;
  logic                     ovl_sticky;
  logic                     sat_flag;

  modport master (
    output ce, vin, coef_we, coef_sel, coef_idx, coef_wdata, coef_commit,
           dith_en, ovl_clr,
    input  pwm, ovl_event, ovl_sticky, sat_flag
  );

  modport slave (
    input  ce, vin, coef_we, coef_sel, coef_idx, coef_wdata, coef_commit,
           dith_en, ovl_clr,
    output pwm, ovl_event, ovl_sticky, sat_flag
  );

endinterface

// File: rtl/dsm_integrator.sv
// dsm_integrator: one CIFB stage.
//   s <= sat(s + ((gain * s_in) >>> COEF_FRAC) - (v ? fb : -fb)) when step=1,
//   or s <= 0 when step=1 and clr=1.
// Ports: clock, reset_n; step (sample enable); clr (overload clear);
//   v (quantizer decision); s_in (previous stage or input sample);
//   fb (feedback magnitude); gain (Q(COEF_FRAC) inter-stage gain);
//   s (stage state); clip (this step's update would saturate).
module dsm_integrator
  import dsm_pkg::*;
#(
  parameter int ACC_W     = 24,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 14
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    step,
  input  logic                    clr,
  input  logic                    v,
  input  logic signed [ACC_W-1:0] s_in,
  input  logic signed [ACC_W-1:0] fb,
  input  logic signed [COEF_W-1:0] gain,
  output logic signed [ACC_W-1:0] s,
  output logic                    clip
);

  wide_t term;
  wide_t sum;
  wide_t sat_v;

  // Whole update is done in 64 bits so nothing wraps before the clip; the
  // arithmetic shift floors toward minus infinity.
  always_comb begin
    term  = (wide_t'(gain) * wide_t'(s_in)) >>> COEF_FRAC;
    sum   = wide_t'(s) + term - (v ? wide_t'(fb) : -wide_t'(fb));
    sat_v = sat(sum, ACC_W);
    clip  = (sat_v != sum);
  end

  // NOTE: state registers use non-blocking assignments so every stage samples
  // the pre-edge values of its neighbours, regardless of evaluation order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s <= '0;
    end else if (step) begin
      s <= clr ? '0 : sat_v[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/dsm_cifb.sv
// dsm_cifb: configurable-order (1..4) CIFB delta-sigma modulator with 1-bit
// output, shadowed runtime coefficients, integrator saturation, optional LFSR
// dither on the quantizer input and overload detection with state clear.
// Ports: clock, reset_n (async, active low); bus (dsm_cifb_if.slave) carries
//   ce/vin sample input, pwm output, coefficient write/commit port, dith_en,
//   and overload/saturation status (ovl_clr, ovl_event, ovl_sticky, sat_flag).
module dsm_cifb
  import dsm_pkg::*;
#(
  parameter int     ORDER     = 2,
  parameter int     DATA_W    = 20,
  parameter int     ACC_W     = 24,
  parameter int     COEF_W    = 16,
  parameter int     COEF_FRAC = 14,
  parameter longint OVL_TH    = longint'(1) << (ACC_W - 2),
  parameter int     OVL_LIMIT = 16,
  parameter int     DITH_W    = 8
) (
  input logic        clock,
  input logic        reset_n,
  dsm_cifb_if.slave  bus
);

  localparam wide_t                    FS     = fs_of(DATA_W);
  localparam logic signed [ACC_W-1:0]  FB_RST = ACC_W'(FS);
  localparam logic signed [COEF_W-1:0] C_ONE  = COEF_W'(longint'(1) << COEF_FRAC);
  localparam int                       CNT_W  = $clog2(OVL_LIMIT + 1);

  logic signed [ACC_W-1:0]  fb_act [MAX_ORDER];
  logic signed [ACC_W-1:0]  fb_sh [MAX_ORDER];
  logic signed [ACC_W-1:0]  fb_sh_nxt [MAX_ORDER];
  logic signed [COEF_W-1:0] c_act [MAX_ORDER];
  logic signed [COEF_W-1:0] c_sh [MAX_ORDER];
  logic signed [COEF_W-1:0] c_sh_nxt [MAX_ORDER];
  logic                     pending;

  logic signed [ACC_W-1:0]  s [ORDER];
  logic [ORDER-1:0]         clip;
  logic signed [ACC_W-1:0]  vin_ext;

  logic [15:0]              lfsr;
  wide_t                    s_last;
  wide_t                    dith;
  wide_t                    q;
  logic                     v;
  logic                     ovl_now;

  ovl_state_e               st, st_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic                     fire;

  logic                     pwm_q, sat_q, event_q, sticky_q;

  assign vin_ext = ACC_W'(bus.vin);

  // Quantizer and overload detector both look at the last integrator.
  always_comb begin
    s_last = wide_t'(s[ORDER-1]);
    dith   = '0;
    if (bus.dith_en) dith = wide_t'(signed'(lfsr[15 -: DITH_W]));
    q       = s_last + dith;
    v       = (q >= 0);
    ovl_now = (s_last > OVL_TH) || (s_last < -OVL_TH);
  end

  for (genvar k = 0; k < ORDER; k++) begin : g_stage
    logic signed [ACC_W-1:0]  s_in;
    logic signed [COEF_W-1:0] gain;
    if (k == 0) begin : g_first
      // First stage takes the input sample at unity gain.
      assign s_in = vin_ext;
      assign gain = C_ONE;
    end else begin : g_next
      assign s_in = s[k-1];
      assign gain = c_act[k];
    end
    dsm_integrator #(
      .ACC_W    (ACC_W),
      .COEF_W   (COEF_W),
      .COEF_FRAC(COEF_FRAC)
    ) u_int (
      .clock  (clock),
      .reset_n(reset_n),
      .step   (bus.ce),
      .clr    (fire),
      .v      (v),
      .s_in   (s_in),
      .fb     (fb_act[k]),
      .gain   (gain),
      .s      (s[k]),
      .clip   (clip[k])
    );
  end

  // Shadow write path; the commit copy uses this so a same-edge write wins.
  // NOTE: every always_comb output gets a default first so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    fb_sh_nxt = fb_sh;
    c_sh_nxt  = c_sh;
    if (bus.coef_we && (int'(bus.coef_idx) < ORDER)) begin
      if (bus.coef_sel == COEF_GAIN) c_sh_nxt[bus.coef_idx] = bus.coef_wdata[COEF_W-1:0];
      else                           fb_sh_nxt[bus.coef_idx] = bus.coef_wdata;
    end
  end

  // Overload FSM: counts consecutive overloaded steps, fires on the last one.
  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    fire    = 1'b0;
    if (bus.ce) begin
      unique case (st)
        OVL_IDLE: begin
          if (ovl_now) begin
            if (OVL_LIMIT <= 1) begin
              fire = 1'b1;
            end else begin
              st_nxt  = OVL_COUNT;
              cnt_nxt = CNT_W'(1);
            end
          end
        end
        OVL_COUNT: begin
          if (!ovl_now) begin
            st_nxt  = OVL_IDLE;
            cnt_nxt = '0;
          end else if (cnt == CNT_W'(OVL_LIMIT - 1)) begin
            fire    = 1'b1;
            st_nxt  = OVL_IDLE;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the coefficient banks are small register files with defined
      // power-up values, so they are reset like any other flop.
      for (int k = 0; k < MAX_ORDER; k++) begin
        fb_act[k] <= FB_RST;
        fb_sh[k]  <= FB_RST;
        c_act[k]  <= C_ONE;
        c_sh[k]   <= C_ONE;
      end
      pending  <= 1'b0;
      lfsr     <= LFSR_SEED;
      st       <= OVL_IDLE;
      cnt      <= '0;
      pwm_q    <= 1'b0;
      sat_q    <= 1'b0;
      event_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      st       <= st_nxt;
      cnt      <= cnt_nxt;
      event_q  <= fire;
      // Setting has priority over ovl_clr, including during the event cycle.
      sticky_q <= fire | event_q | (sticky_q & ~bus.ovl_clr);
      fb_sh    <= fb_sh_nxt;
      c_sh     <= c_sh_nxt;
      if (bus.ce) begin
        pwm_q <= v;
        sat_q <= |clip;
        lfsr  <= lfsr_next(lfsr);
        if (pending) begin
          fb_act <= fb_sh_nxt;
          c_act  <= c_sh_nxt;
        end
        // A commit seen on a step edge waits for the next step.
        pending <= bus.coef_commit;
      end else begin
        pending <= pending | bus.coef_commit;
      end
    end
  end

  assign bus.pwm        = pwm_q;
  assign bus.sat_flag   = sat_q;
  assign bus.ovl_event  = event_q;
  assign bus.ovl_sticky = sticky_q;

endmodule
